// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a four-digit multiplexed seven-segment bus (AN/segN, active-low).
// Filters each scanned digit, decodes it back to BCD and publishes all four digits once per frame.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] AN,
    input  logic [6:0] segN,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic [3:0] digit_x,
    output logic [3:0] digit_err,
    output logic       frame_valid
);

    localparam int unsigned       SAMP_W    = 11;
    localparam int unsigned       DIGITS    = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SETTLE_CYCLES);
    // Capture fires on the edge where the counter moves from SETTLE-2 to SETTLE-1.
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [SAMP_W-1:0] SAMP_IDLE = SAMP_W'(11'h7FF);

    logic [SAMP_W-1:0]        samp_q, samp_d;
    logic [SAMP_W-1:0]        prev_q, prev_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DIGITS-1:0]        seen_q, seen_d;
    logic [DIGITS-1:0][3:0]   slot_bcd_q, slot_bcd_d;
    logic [DIGITS-1:0]        slot_x_q, slot_x_d;
    logic [DIGITS-1:0]        slot_err_q, slot_err_d;
    logic [DIGITS-1:0][3:0]   out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0]        out_x_q, out_x_d;
    logic [DIGITS-1:0]        out_err_q, out_err_d;
    logic                     frame_valid_q, frame_valid_d;

    logic                     stable_c;
    logic                     an_ok_c;
    logic [1:0]               an_idx_c;
    logic                     capture_c;
    logic                     frame_done_c;
    logic [3:0]               dec_bcd_c;
    logic                     dec_x_c;
    logic                     dec_err_c;

    // Input sampling and settle counter.
    always_comb begin
        samp_d   = {AN, segN};
        prev_d   = samp_q;
        stable_c = (samp_q == prev_q);
        cnt_d    = cnt_q;
        if (!stable_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Anode must select exactly one digit.
    always_comb begin
        an_ok_c  = 1'b1;
        an_idx_c = 2'd0;
        case (samp_q[10:7])
            4'b1110: an_idx_c = 2'd0;
            4'b1101: an_idx_c = 2'd1;
            4'b1011: an_idx_c = 2'd2;
            4'b0111: an_idx_c = 2'd3;
            default: an_ok_c  = 1'b0;
        endcase
    end

    // Segment pattern back to BCD.
    always_comb begin
        dec_bcd_c = 4'd0;
        dec_x_c   = 1'b0;
        dec_err_c = 1'b0;
        case (samp_q[6:0])
            7'b1000000: dec_bcd_c = 4'd0;
            7'b1111001: dec_bcd_c = 4'd1;
            7'b0100100: dec_bcd_c = 4'd2;
            7'b0110000: dec_bcd_c = 4'd3;
            7'b0011001: dec_bcd_c = 4'd4;
            7'b0010010: dec_bcd_c = 4'd5;
            7'b0000010: dec_bcd_c = 4'd6;
            7'b1111000: dec_bcd_c = 4'd7;
            7'b0000000: dec_bcd_c = 4'd8;
            7'b0010000: dec_bcd_c = 4'd9;
            7'b0001001: begin
                dec_bcd_c = 4'hF;
                dec_x_c   = 1'b1;
            end
            default:    dec_err_c = 1'b1;
        endcase
    end

    assign capture_c    = stable_c && (cnt_q == CNT_PRE) && an_ok_c;
    assign frame_done_c = (seen_q == 4'b1111);

    // Slot capture and frame publish; a capture on the publish cycle lands in the new frame.
    always_comb begin
        slot_bcd_d    = slot_bcd_q;
        slot_x_d      = slot_x_q;
        slot_err_d    = slot_err_q;
        seen_d        = seen_q;
        out_bcd_d     = out_bcd_q;
        out_x_d       = out_x_q;
        out_err_d     = out_err_q;
        frame_valid_d = 1'b0;

        if (frame_done_c) begin
            out_bcd_d     = slot_bcd_q;
            out_x_d       = slot_x_q;
            out_err_d     = slot_err_q;
            frame_valid_d = 1'b1;
            seen_d        = '0;
        end

        if (capture_c) begin
            if (!dec_err_c) begin
                slot_bcd_d[an_idx_c] = dec_bcd_c;
            end
            slot_x_d[an_idx_c]   = dec_x_c;
            slot_err_d[an_idx_c] = dec_err_c;
            seen_d[an_idx_c]     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q        <= SAMP_IDLE;
            prev_q        <= SAMP_IDLE;
            cnt_q         <= '0;
            seen_q        <= '0;
            slot_bcd_q    <= '0;
            slot_x_q      <= '0;
            slot_err_q    <= '0;
            out_bcd_q     <= '0;
            out_x_q       <= '0;
            out_err_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            samp_q        <= samp_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            slot_bcd_q    <= slot_bcd_d;
            slot_x_q      <= slot_x_d;
            slot_err_q    <= slot_err_d;
            out_bcd_q     <= out_bcd_d;
            out_x_q       <= out_x_d;
            out_err_q     <= out_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign BCD0        = out_bcd_q[0];
    assign BCD1        = out_bcd_q[1];
    assign BCD2        = out_bcd_q[2];
    assign BCD3        = out_bcd_q[3];
    assign digit_x     = out_x_q;
    assign digit_err   = out_err_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scan scenarios plus random windows,
// checked against a window-level reference model of the display scan.
module tb_seven_seg_scan_decoder;

    localparam int unsigned S = 4;
    localparam logic [6:0] SEG_X = 7'b0001001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] an_i;
    logic [6:0] seg_i;
    logic [3:0] BCD0, BCD1, BCD2, BCD3, digit_x, digit_err;
    logic       frame_valid;
    logic [23:0] out_word;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .AN(an_i), .segN(seg_i),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
        .digit_x(digit_x), .digit_err(digit_err), .frame_valid(frame_valid)
    );

    assign out_word = {BCD3, BCD2, BCD1, BCD0, digit_x, digit_err};

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_pass   = 0;
    int fv_total = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    // Reference model state: one entry per digit of the current frame.
    logic [3:0][3:0] m_slot;
    logic [3:0]      m_sx, m_serr, m_seen;
    logic [23:0]     m_out;
    logic [10:0]     m_last;
    int              m_run;
    bit              m_capd;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            got_q.push_back(out_word);
            fv_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_slot = '0; m_sx = '0; m_serr = '0; m_seen = '0; m_out = '0;
        m_last = 11'h7FF; m_run = 0; m_capd = 1'b1;
    endtask

    task automatic model_capture(input logic [3:0] an, input logic [6:0] seg);
        int  idx;
        bit  found;
        logic [3:0] pat;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            pat = 4'(~(4'b0001 << i));
            if (an == pat) idx = i;
        end
        if (idx < 0) return;
        found = 1'b0;
        for (int d = 0; d < 10; d++) begin
            if (seg == seg_tab[d]) begin
                m_slot[idx] = 4'(d); m_sx[idx] = 1'b0; m_serr[idx] = 1'b0; found = 1'b1;
            end
        end
        if (!found) begin
            if (seg == SEG_X) begin
                m_slot[idx] = 4'hF; m_sx[idx] = 1'b1; m_serr[idx] = 1'b0;
            end else begin
                m_sx[idx] = 1'b0; m_serr[idx] = 1'b1;
            end
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            m_out = {m_slot, m_sx, m_serr};
            exp_q.push_back(m_out);
            m_seen = '0;
        end
    endtask

    // Hold one {AN,segN} value for 'hold' clock edges; called and returns on a falling edge.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold);
        an_i = an; seg_i = seg;
        if ({an, seg} == m_last) m_run += hold;
        else begin
            m_run = hold; m_capd = 1'b0; m_last = {an, seg};
        end
        if (!m_capd && m_run >= int'(S)) begin
            m_capd = 1'b1;
            model_capture(an, seg);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic digit(input int pos, input int val, input int hold);
        drive(4'(~(4'b0001 << pos)), seg_tab[val], hold);
    endtask

    task automatic compare_frames(input string tag);
        int n;
        drive(4'hF, 7'h7F, int'(S) + 3);
        check({tag, " frame count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " frame"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, " held outputs"}, 32'(out_word), 32'(m_out));
        check({tag, " frame_valid idle"}, 32'(frame_valid), 32'(0));
        got_q.delete();
        exp_q.delete();
    endtask

    // Async reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic reset_midcycle(input string tag);
        an_i = 4'hF; seg_i = 7'h7F;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check({tag, " outputs during reset"}, 32'({out_word, frame_valid}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int fv0;
        logic [3:0] an;
        logic [6:0] seg;
        int r;
        int k;

        rst_n = 1'b0; an_i = 4'hF; seg_i = 7'h7F;
        model_reset();
        @(negedge clk);
        check("power-on reset outputs", 32'({out_word, frame_valid}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Loopback of a driver scanning 1,2,3,4 for five refresh periods.
        fv0 = fv_total;
        for (int s = 0; s < 5; s++)
            for (int p = 0; p < 4; p++) digit(p, p + 1, 8);
        compare_frames("loopback");
        check("loopback pulses", 32'(fv_total - fv0), 32'(5));
        check("loopback digits", 32'(out_word), 32'({4'd4, 4'd3, 4'd2, 4'd1, 8'h00}));

        reset_midcycle("midcycle");
        @(negedge clk);
        check("after reset outputs", 32'({out_word, frame_valid}), 32'(0));

        // Glitch shorter than the settle window must not mark digit 0 as seen.
        fv0 = fv_total;
        drive(4'b1110, seg_tab[1], 2);
        drive(4'hF, 7'h7F, 6);
        digit(1, 1, 6); digit(2, 2, 6); digit(3, 3, 6);
        compare_frames("glitch");
        check("glitch no frame", 32'(fv_total - fv0), 32'(0));
        digit(0, 5, 6);
        compare_frames("glitch complete");
        check("glitch completes once", 32'(fv_total - fv0), 32'(1));
        check("glitch digits", 32'(out_word), 32'({4'd3, 4'd2, 4'd1, 4'd5, 8'h00}));

        fv0 = fv_total;
        digit(0, 5, 6); digit(1, 6, 6); drive(4'b1011, SEG_X, 6); digit(3, 7, 6);
        compare_frames("x pattern");
        check("x pattern pulses", 32'(fv_total - fv0), 32'(1));
        check("x pattern digits", 32'(out_word), 32'({4'd7, 4'hF, 4'd6, 4'd5, 4'b0100, 4'b0000}));

        fv0 = fv_total;
        digit(0, 2, 6); drive(4'b1101, 7'h7F, 6); drive(4'b1100, seg_tab[8], 6);
        digit(2, 3, 6); digit(3, 4, 6);
        compare_frames("invalid");
        check("invalid pulses", 32'(fv_total - fv0), 32'(1));
        check("invalid digits", 32'(out_word), 32'({4'd4, 4'd3, 4'd6, 4'd2, 4'b0000, 4'b0010}));

        digit(0, 1, 6); digit(1, 1, 6);
        reset_midcycle("midframe");
        fv0 = fv_total;
        digit(0, 9, 6); digit(1, 8, 6); digit(2, 7, 6); digit(3, 6, 6);
        compare_frames("midframe");
        check("midframe pulses", 32'(fv_total - fv0), 32'(1));
        check("midframe digits", 32'(out_word), 32'({4'd6, 4'd7, 4'd8, 4'd9, 8'h00}));

        // Random windows of mixed anodes, patterns and hold lengths.
        for (int w = 0; w < 400; w++) begin
            r = int'($urandom_range(0, 9));
            k = int'($urandom_range(0, 3));
            if (r < 6)      an = 4'(~(4'b0001 << k));
            else if (r < 8) an = 4'hF;
            else            an = 4'($urandom);
            r = int'($urandom_range(0, 9));
            k = int'($urandom_range(0, 9));
            if (r < 7)      seg = seg_tab[k];
            else if (r < 8) seg = SEG_X;
            else            seg = 7'($urandom);
            drive(an, seg, int'($urandom_range(1, 8)));
            if (w % 50 == 49) compare_frames("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
